// File: rtl/comparador_serial_desigualdade.sv
// comparador_serial_desigualdade: serial A/B frame inequality compare, optional HAMMING_DIST_EN distance count
module comparador_serial_desigualdade #(
   parameter int LARGURA = 6
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       inicio,
   input  logic       valido,
   input  logic       a_bit,
   input  logic       b_bit,
   output logic       ocupado,
   output logic       pronto,
`ifdef HAMMING_DIST_EN
   output logic [2:0] distancia,
`endif
   output logic       diferente
);
   typedef enum logic [1:0] {IDLE, RECEBE, FIM} estado_t;
   estado_t estado, proximo;
   logic [2:0] cont;
   logic acc, aceita, ultimo, limpa, par_dif;
   assign par_dif = a_bit ^ b_bit;
   assign aceita  = estado == RECEBE && valido;
   assign ultimo  = aceita && cont == 3'(LARGURA - 1);
   assign limpa   = inicio && estado != RECEBE;
   // state register
   always_ff @(posedge clk)
      estado <= reset ? IDLE : proximo;
   // next state and state-decoded outputs
   always_comb begin
      proximo = estado == RECEBE ? (ultimo ? FIM : RECEBE) : (inicio ? RECEBE : IDLE);
      ocupado = estado == RECEBE;
      pronto  = estado == FIM;
   end
   // pair counter, mismatch accumulator and result register
   always_ff @(posedge clk)
      if (reset) begin
         cont      <= '0;
         acc       <= 1'b0;
         diferente <= 1'b0;
      end else begin
         if (limpa) begin
            cont <= '0;
            acc  <= 1'b0;
         end else if (aceita) begin
            cont <= cont + 3'd1;
            acc  <= acc | par_dif;
         end
         if (ultimo)
            diferente <= acc | par_dif;
      end
`ifdef HAMMING_DIST_EN
   logic [2:0] dist_acc;
   // differing-pair counter, loaded into distancia alongside diferente
   always_ff @(posedge clk)
      if (reset) begin
         dist_acc  <= '0;
         distancia <= '0;
      end else begin
         if (limpa)
            dist_acc <= '0;
         else if (aceita)
            dist_acc <= dist_acc + {2'b00, par_dif};
         if (ultimo)
            distancia <= dist_acc + {2'b00, par_dif};
      end
`endif
endmodule

// File: tb/tb_comparador_serial_desigualdade.sv
// tb_comparador_serial_desigualdade: directed self-checking bench
module tb_comparador_serial_desigualdade;
   logic clk = 1'b0, reset = 1'b1, inicio = 1'b0, valido = 1'b0, a_bit = 1'b0, b_bit = 1'b0;
   logic ocupado, pronto, diferente;
`ifdef HAMMING_DIST_EN
   logic [2:0] distancia;
`endif
   int n_chk = 0, n_err = 0;

   comparador_serial_desigualdade #(.LARGURA(6)) dut (
      .clk(clk), .reset(reset), .inicio(inicio), .valido(valido),
      .a_bit(a_bit), .b_bit(b_bit), .ocupado(ocupado), .pronto(pronto),
`ifdef HAMMING_DIST_EN
      .distancia(distancia),
`endif
      .diferente(diferente)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_dist(input string tag, input logic [2:0] exp);
`ifdef HAMMING_DIST_EN
      check(tag, {5'b0, distancia}, {5'b0, exp});
`endif
   endtask

   task automatic frame(input logic [5:0] a, input logic [5:0] b, input bit stall, input bit start,
                        input bit chain, input logic exp_dif, input logic [2:0] exp_dist);
      int busy = 0, pr = 0;
      logic prev;
      prev = diferente;
      if (start) begin
         inicio = 1'b1; valido = 1'b1; a_bit = 1'b1; b_bit = 1'b0;
         tick;
      end
      inicio = 1'b0;
      busy += int'(ocupado);
      for (int i = 0; i < 6; i++) begin
         valido = 1'b1; a_bit = a[i]; b_bit = b[i];
         if (chain && i == 5) inicio = 1'b1;
         tick;
         valido = 1'b0; a_bit = 1'b1; b_bit = 1'b0;
         if (i < 5) begin
            busy += int'(ocupado);
            pr += int'(pronto);
         end
         if (i == 2) check("hold_mid_frame", diferente, prev);
         if (stall && (i == 1 || i == 3))
            repeat (2) begin
               tick;
               busy += int'(ocupado);
               pr += int'(pronto);
            end
      end
      check("pronto_end", pronto, 1'b1);
      check("ocupado_end", ocupado, 1'b0);
      check("diferente", diferente, exp_dif);
      check_dist("distancia", exp_dist);
      check("busy_cycles", 8'(busy), stall ? 8'd10 : 8'd6);
      check("early_pronto", 8'(pr), 8'd0);
      tick;
      inicio = 1'b0;
      check("pronto_one_cycle", pronto, 1'b0);
      check(chain ? "chain_ocupado" : "back_idle", ocupado, chain);
   endtask

   initial begin
      tick; tick;
      check("rst_ocupado", ocupado, 1'b0);
      check("rst_pronto", pronto, 1'b0);
      check("rst_diferente", diferente, 1'b0);
      check_dist("rst_distancia", 3'd0);
      reset = 1'b0;
      valido = 1'b1; a_bit = 1'b1; b_bit = 1'b0;
      repeat (3) begin
         tick;
         check("idle_ignore_ocupado", ocupado, 1'b0);
         check("idle_ignore_pronto", pronto, 1'b0);
      end
      valido = 1'b0;
      frame(6'b101010, 6'b010101, 1'b0, 1'b1, 1'b0, 1'b1, 3'd6);
      frame(6'b010101, 6'b010101, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
      frame(6'b000001, 6'b000000, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1);
      frame(6'b111111, 6'b111110, 1'b1, 1'b1, 1'b0, 1'b1, 3'd1);
      inicio = 1'b1;
      tick;
      inicio = 1'b0;
      for (int i = 0; i < 3; i++) begin
         valido = 1'b1; a_bit = i[0]; b_bit = ~i[0];
         tick;
      end
      reset = 1'b1; inicio = 1'b1; valido = 1'b1;
      tick;
      reset = 1'b0; inicio = 1'b0; valido = 1'b0;
      check("midrst_ocupado", ocupado, 1'b0);
      check("midrst_pronto", pronto, 1'b0);
      check("midrst_diferente", diferente, 1'b0);
      check_dist("midrst_distancia", 3'd0);
      repeat (4) begin
         tick;
         check("midrst_no_pronto", pronto, 1'b0);
      end
      frame(6'b000000, 6'b000000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
      frame(6'b101010, 6'b010101, 1'b0, 1'b1, 1'b1, 1'b1, 3'd6);
      frame(6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/comparador_serial_desigualdade.md
COMPARADOR_SERIAL_DESIGUALDADE -- requirements
Module: comparador_serial_desigualdade

Interface
REQ-001 The block SHALL have one parameter, LARGURA, default 6, giving the number of bit pairs per frame (legal range 2..7).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 inicio  input  1  start-of-frame request.
REQ-005 valido  input  1  qualifies a_bit/b_bit as one bit pair in the current cycle.
REQ-006 a_bit  input  1  serial bit of operand A, LSB first.
REQ-007 b_bit  input  1  serial bit of operand B, LSB first.
REQ-008 ocupado  output  1  high while a frame is being received (state RECEBE).
REQ-009 pronto  output  1  one-cycle pulse when a frame result is valid.
REQ-010 diferente  output  1  registered result of the last completed frame: 1 if any bit pair differed.
REQ-011 distancia  output  3  number of differing bit pairs in the last completed frame; present only with HAMMING_DIST_EN.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RECEBE and FIM.
REQ-013 In IDLE, inicio=1 SHALL move the FSM to RECEBE and clear the bit counter and mismatch accumulator; a_bit/b_bit SHALL NOT be sampled in that cycle.
REQ-014 In RECEBE, each cycle with valido=1 SHALL OR (a_bit XOR b_bit) into the accumulator and increment the bit counter.
REQ-015 In RECEBE, valido=0 SHALL stall: the counter and accumulator hold, and there is no timeout.
REQ-016 In RECEBE, inicio SHALL be ignored.
REQ-017 When the pair accepted is number LARGURA (counter = LARGURA-1 with valido=1), the FSM SHALL move to FIM.
REQ-018 On that same edge, diferente SHALL load the final accumulator value, including the last pair.
REQ-019 In FIM, pronto SHALL be 1 for exactly one cycle, and the FSM SHALL then go to IDLE.
REQ-020 If inicio=1 in FIM, the FSM SHALL go directly to RECEBE (back-to-back frames), with the same clearing as REQ-013.
REQ-021 Latency: pronto SHALL assert on the cycle immediately after the cycle that accepts the last valid pair.
REQ-022 diferente (and distancia) SHALL hold the last result until the next frame completes; an in-progress frame SHALL NOT change them.
REQ-023 ocupado SHALL be 1 only in RECEBE; pronto SHALL be 1 only in FIM.
REQ-024 valido, a_bit and b_bit SHALL be ignored in IDLE and FIM.

Reset
REQ-025 With reset=1 at a clock edge, the FSM SHALL go to IDLE and clear the bit counter and accumulator.
REQ-026 With reset=1 at a clock edge, ocupado=0, pronto=0, diferente=0 and distancia=0.
REQ-027 reset SHALL take priority over inicio and valido.
REQ-028 A reset mid-frame SHALL discard the partial frame, and pronto SHALL NOT be generated for it.

Configuration
REQ-029 With HAMMING_DIST_EN defined, the block SHALL count the pairs with a_bit != b_bit in the frame.
REQ-030 With HAMMING_DIST_EN defined, distancia SHALL load this count on the same edge as diferente.
REQ-031 With HAMMING_DIST_EN defined, diferente SHALL equal (distancia != 0).
REQ-032 Without HAMMING_DIST_EN, the distancia port and its counter SHALL be absent, and diferente behaviour SHALL be unchanged.

Verification
REQ-033 Frame A=101010, B=010101, valido held high -> pronto 1 cycle after the 6th pair; diferente=1; distancia=6.
REQ-034 Frame A=B=010101 -> diferente=0, distancia=0; then frame A=000001, B=000000 -> diferente=1, distancia=1.
REQ-035 Frame A=111111, B=111110 with valido low for 2 cycles after pairs 2 and 4 -> pronto 1 cycle after the 6th valid pair; diferente=1; distancia=1; ocupado high for 10 cycles.
REQ-036 reset asserted after 3 pairs of A=101010, B=010101 -> next cycle ocupado=0, diferente=0; no pronto; a fresh frame A=B=000000 then gives diferente=0.
REQ-037 inicio held high in FIM with back-to-back frames (101010/010101, then 000000/000000) -> second frame starts with no IDLE cycle; pronto pulses twice; diferente 1 then 0.
